// File: rtl/match_accumulator.sv
// Converts adder-tree mismatch counts into signed segment correlations and sums SEG_NUM of them per code phase.
// Define PEAK_SEARCH_EN to track the peak |correlation| and its index across a sweep.
module match_accumulator #(
    parameter int SEG_NUM = 3,
    parameter int SEG_LEN = 341
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [9:0]         sweep_len,
    input  logic               in_valid,
    input  logic [8:0]         cnt_in,
    output logic               corr_valid,
    output logic signed [10:0] corr_out,
    output logic [9:0]         corr_index,
    output logic [9:0]         peak_value,
    output logic [9:0]         peak_index,
    output logic               done,
    output logic               busy
);

    localparam int SEG_CW = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
    localparam int TOT_W  = $clog2(1024 * SEG_NUM + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state;
    logic [SEG_CW-1:0]   seg_cnt;
    logic signed [10:0]  acc;
    logic [9:0]          idx_cnt;
    logic [9:0]          sweep_len_reg;
    logic [TOT_W-1:0]    accept_cnt;
    logic [TOT_W-1:0]    seg_total;
    logic [1:0]          vld_dly;

    logic                restart;
    logic                accept;
    logic                seg_last;
    logic signed [9:0]   seg;
    logic signed [10:0]  seg_ext;
    logic signed [10:0]  sum;

    always_comb begin
        restart  = start && (sweep_len != 10'd0);
        // start wins over a coincident in_valid; accepting begins the next cycle
        accept   = (state == RUN) && in_valid && !start;
        seg      = 10'(SEG_LEN) - {cnt_in, 1'b0};
        seg_ext  = {seg[9], seg};
        sum      = (seg_cnt == '0) ? seg_ext : acc + seg_ext;
        seg_last = (seg_cnt == SEG_CW'(SEG_NUM - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            seg_cnt       <= '0;
            acc           <= '0;
            idx_cnt       <= '0;
            sweep_len_reg <= '0;
            accept_cnt    <= '0;
            seg_total     <= '0;
            vld_dly       <= '0;
            corr_valid    <= 1'b0;
            corr_out      <= '0;
            corr_index    <= '0;
            done          <= 1'b0;
        end else if (restart) begin
            // Aborts any sweep in progress: in-flight segments are dropped with the delay line
            state         <= RUN;
            seg_cnt       <= '0;
            acc           <= '0;
            idx_cnt       <= '0;
            sweep_len_reg <= sweep_len;
            accept_cnt    <= '0;
            seg_total     <= TOT_W'(sweep_len) * TOT_W'(SEG_NUM);
            vld_dly       <= '0;
            corr_valid    <= 1'b0;
            corr_out      <= '0;
            corr_index    <= '0;
            done          <= 1'b0;
        end else begin
            corr_valid <= 1'b0;
            done       <= 1'b0;
            vld_dly    <= {vld_dly[0], accept};

            if (accept)
                accept_cnt <= accept_cnt + TOT_W'(1);

            case (state)
                RUN:     if (accept && (accept_cnt == seg_total - TOT_W'(1))) state <= FLUSH;
                FLUSH:   if (done) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (vld_dly[1]) begin
                acc <= sum;
                if (seg_last) begin
                    seg_cnt    <= '0;
                    corr_out   <= sum;
                    corr_valid <= 1'b1;
                    corr_index <= idx_cnt;
                    idx_cnt    <= idx_cnt + 10'd1;
                    if (idx_cnt == sweep_len_reg - 10'd1)
                        done <= 1'b1;
                end else begin
                    seg_cnt <= seg_cnt + SEG_CW'(1);
                end
            end
        end
    end

`ifdef PEAK_SEARCH_EN
    logic       corr_fire;
    logic [9:0] mag;

    // Magnitude of the value being registered into corr_out this cycle; -1023 maps to 1023
    assign corr_fire = vld_dly[1] && seg_last;
    assign mag       = sum[10] ? 10'(-sum) : 10'(sum);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            peak_value <= '0;
            peak_index <= '0;
        end else if (restart) begin
            peak_value <= '0;
            peak_index <= '0;
        end else if (corr_fire && (mag > peak_value)) begin
            // strictly greater: ties keep the earliest index
            peak_value <= mag;
            peak_index <= idx_cnt;
        end
    end
`else
    assign peak_value = '0;
    assign peak_index = '0;
`endif

endmodule

// File: tb/tb_match_accumulator.sv
// Directed bench for match_accumulator: reset, full-scale correlations, gapped sweep,
// ignored in_valid outside RUN, mid-sweep restart and asynchronous reset.
module tb_match_accumulator;

    logic               clk = 1'b0;
    logic               rst_b;
    logic               start;
    logic [9:0]         sweep_len;
    logic               in_valid;
    logic [8:0]         cnt_in;
    logic               corr_valid;
    logic signed [10:0] corr_out;
    logic [9:0]         corr_index;
    logic [9:0]         peak_value;
    logic [9:0]         peak_index;
    logic               done;
    logic               busy;

    always #5 clk = ~clk;

    match_accumulator dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .sweep_len  (sweep_len),
        .in_valid   (in_valid),
        .cnt_in     (cnt_in),
        .corr_valid (corr_valid),
        .corr_out   (corr_out),
        .corr_index (corr_index),
        .peak_value (peak_value),
        .peak_index (peak_index),
        .done       (done),
        .busy       (busy)
    );

`ifdef PEAK_SEARCH_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    typedef struct {
        int c;
        int val;
        int idx;
        int pv;
        int pi;
        bit dn;
        bit bz;
    } ev_t;

    ev_t        ev_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [8:0] cpipe0 = '0;
    logic [8:0] cpipe1 = '0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle; cnt_in replays the value given with in_valid two cycles earlier
    task automatic step(input bit v, input int c, input bit s, input int sl);
        ev_t e;
        in_valid  = v;
        start     = s;
        sweep_len = 10'(sl);
        cnt_in    = cpipe1;
        @(posedge clk);
        #1;
        cpipe1 = cpipe0;
        cpipe0 = 9'(c);
        cyc++;
        if (corr_valid) begin
            e.c   = cyc;
            e.val = int'(corr_out);
            e.idx = int'(corr_index);
            e.pv  = int'(peak_value);
            e.pi  = int'(peak_index);
            e.dn  = done;
            e.bz  = busy;
            ev_q.push_back(e);
            $display("cyc %0d corr idx %0d val %0d peak %0d@%0d done %0d",
                     cyc, e.idx, e.val, e.pv, e.pi, e.dn);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 0);
    endtask

    task automatic seg(input int c);
        step(1'b1, c, 1'b0, 0);
    endtask

    function automatic ev_t get_ev(input int i);
        ev_t e;
        e = '{default: 0};
        if (i < ev_q.size()) e = ev_q[i];
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   k;
        ev_t  e;
        int   c_seg [12] = '{161, 150, 150, 220, 221, 221, 120, 120, 121, 300, 300, 62};
        int   c_exp [4]  = '{101, -301, 301, -301};

        rst_b = 1'b0; start = 1'b0; in_valid = 1'b0; sweep_len = '0; cnt_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cv",   int'(corr_valid), 0);
        check("rst_out",  int'(corr_out), 0);
        check("rst_idx",  int'(corr_index), 0);
        check("rst_pv",   int'(peak_value), 0);
        check("rst_pi",   int'(peak_index), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        rst_b = 1'b1;
        idle(2);

        // sweep_len 1, all chips matching
        ev_q.delete();
        step(1'b0, 0, 1'b1, 1);
        check("a_busy", int'(busy), 1);
        seg(0); seg(0); k = cyc; seg(0);
        idle(6);
        e = get_ev(0);
        check("a_n",     ev_q.size(), 1);
        check("a_val",   e.val, 1023);
        check("a_idx",   e.idx, 0);
        check("a_lat",   e.c, k + 3);
        check("a_done",  int'(e.dn), 1);
        check("a_bzdn",  int'(e.bz), 1);
        check("a_pv",    e.pv, PEAK_EN ? 1023 : 0);
        check("a_pi",    e.pi, 0);
        check("a_bzend", int'(busy), 0);

        // sweep_len 1, all chips mismatching
        ev_q.delete();
        step(1'b0, 0, 1'b1, 1);
        seg(341); seg(341); seg(341);
        idle(6);
        e = get_ev(0);
        check("b_n",    ev_q.size(), 1);
        check("b_val",  e.val, -1023);
        check("b_pv",   e.pv, PEAK_EN ? 1023 : 0);
        check("b_done", int'(e.dn), 1);

        // sweep_len 4 with gaps between segments; tie on 301 keeps index 1
        ev_q.delete();
        step(1'b0, 0, 1'b1, 4);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            k = cyc;
            seg(c_seg[i]);
            if (i != 11) idle(1 + (i % 2));
        end
        idle(6);
        check("c_n", ev_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            e = get_ev(i);
            check($sformatf("c_val%0d", i),  e.val, c_exp[i]);
            check($sformatf("c_idx%0d", i),  e.idx, i);
            check($sformatf("c_done%0d", i), int'(e.dn), (i == 3) ? 1 : 0);
        end
        e = get_ev(0);
        check("c_pv0", e.pv, PEAK_EN ? 101 : 0);
        e = get_ev(3);
        check("c_pv3", e.pv, PEAK_EN ? 301 : 0);
        check("c_pi3", e.pi, PEAK_EN ? 1 : 0);
        check("c_lat", e.c, k + 3);

        // in_valid in IDLE and FLUSH must be ignored
        ev_q.delete();
        seg(0); seg(0); seg(0);
        idle(4);
        check("d_idle_n",    ev_q.size(), 0);
        check("d_idle_busy", int'(busy), 0);
        step(1'b0, 0, 1'b1, 1);
        seg(100); seg(100); seg(100);
        seg(0); seg(0); seg(0);
        seg(0); seg(0); seg(0);
        idle(4);
        e = get_ev(0);
        check("d_n",    ev_q.size(), 1);
        check("d_val",  e.val, 423);
        check("d_idx",  e.idx, 0);
        check("d_done", int'(e.dn), 1);

        // restart after 5 of 12 segments; in_valid coincident with start is dropped
        ev_q.delete();
        step(1'b0, 0, 1'b1, 4);
        repeat (5) seg(0);
        e = get_ev(0);
        check("e_pre_n",   ev_q.size(), 1);
        check("e_pre_val", e.val, 1023);
        ev_q.delete();
        step(1'b1, 0, 1'b1, 1);
        check("e_cv0",   int'(corr_valid), 0);
        check("e_out0",  int'(corr_out), 0);
        check("e_pvclr", int'(peak_value), 0);
        check("e_busy",  int'(busy), 1);
        seg(10); seg(20); k = cyc; seg(30);
        idle(8);
        e = get_ev(0);
        check("e_n",    ev_q.size(), 1);
        check("e_val",  e.val, 903);
        check("e_idx",  e.idx, 0);
        check("e_done", int'(e.dn), 1);
        check("e_lat",  e.c, k + 3);
        check("e_pv",   e.pv, PEAK_EN ? 903 : 0);
        check("e_pi",   e.pi, 0);

        // asynchronous reset mid-RUN with in_valid held
        ev_q.delete();
        step(1'b0, 0, 1'b1, 2);
        repeat (5) seg(50);
        e = get_ev(0);
        check("f_pre_n",   ev_q.size(), 1);
        check("f_pre_val", e.val, 723);
        rst_b = 1'b0;
        #2;
        check("f_cv",   int'(corr_valid), 0);
        check("f_out",  int'(corr_out), 0);
        check("f_idx",  int'(corr_index), 0);
        check("f_pv",   int'(peak_value), 0);
        check("f_done", int'(done), 0);
        check("f_busy", int'(busy), 0);
        repeat (2) seg(50);
        rst_b = 1'b1;
        ev_q.delete();
        repeat (8) seg(0);
        check("f_post_n",    ev_q.size(), 0);
        check("f_post_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
